// File: rtl/midi_transmitter.sv
// midi_transmitter: FIFO-fed 31.25 kbaud MIDI serializer (8N1, line idles high).
// Define MIDI_TX_RUNNING_STATUS_EN to drop repeated channel-status bytes.
module midi_transmitter #(
  parameter int CLKS_PER_BIT = 128,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       midi_out,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            midi_out_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q, count_d;
  logic            full, push, pop, skip, send, last_tick;
  logic [7:0]      head;
  assign full      = count_q == (AW+1)'(FIFO_DEPTH);
  assign push      = tx_valid && !full;
  assign head      = mem_q[rptr_q];
  assign last_tick = timer_q == TW'(CLKS_PER_BIT - 1);
  // The FIFO is only read in IDLE or on the final clock of a stop bit.
  assign pop       = (count_q != '0) && (state_q == IDLE || (state_q == STOP && last_tick));
  assign send      = pop && !skip;
  assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign tx_ready  = !full;
  assign midi_out  = midi_out_q;
  assign busy      = state_q != IDLE || count_q != '0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] rs_q;
  logic       rs_v_q;
  assign skip = pop && head >= 8'h80 && head <= 8'hEF && rs_v_q && head == rs_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q   <= '0;
      rs_v_q <= 1'b0;
    end else if (send) begin
      if (head >= 8'h80 && head <= 8'hEF) begin
        rs_q   <= head;
        rs_v_q <= 1'b1;
      end else if (head >= 8'hF0 && head <= 8'hF7) begin
        rs_v_q <= 1'b0;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= tx_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end
  // The line register follows the current state, so it trails state changes by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      midi_out_q <= 1'b1;
    end else begin
      midi_out_q <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
      case (state_q)
        IDLE: begin
          if (send) begin
            shift_q <= head;
            timer_q <= '0;
            state_q <= START;
          end
        end
        START: begin
          timer_q <= last_tick ? '0 : timer_q + 1'b1;
          if (last_tick) begin
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          timer_q <= last_tick ? '0 : timer_q + 1'b1;
          if (last_tick) begin
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        end
        default: begin
          timer_q <= last_tick ? '0 : timer_q + 1'b1;
          if (last_tick) begin
            state_q <= send ? START : IDLE;
            if (send) shift_q <= head;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_midi_transmitter.sv
// tb_midi_transmitter: vector table, scoreboard-backed frame decoder, corner-case sequences.
module tb_midi_transmitter;
  localparam int C = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, midi_out, busy;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int frames = 0;
  bit in_frame = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  logic [7:0] m_rs = '0;
  bit m_rs_v = 0;
  logic [7:0] mb;
  logic msb, mstop;
  bit mab;
  int mst;

  midi_transmitter #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .midi_out(midi_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model(input logic [7:0] b);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (b >= 8'h80 && b <= 8'hEF) begin
      if (m_rs_v && b == m_rs) return;
      m_rs = b;
      m_rs_v = 1;
    end else if (b >= 8'hF0 && b <= 8'hF7) m_rs_v = 0;
`endif
    exp_q.push_back(b);
  endtask

  task automatic push(input logic [7:0] b);
    logic rdy;
    int n;
    n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    do begin
      rdy = tx_ready;
      @(posedge clk);
      #1 n++;
    end while (!rdy && n < 1000);
    tx_valid = 1'b0;
    if (rdy) model(b);
    else chk("push_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    m_rs_v = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || in_frame) && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    chk(name, 32'(n < 3000 && exp_q.size() == 0), 32'd1);
  endtask

  // Frame decoder: samples the middle of each bit and scores against the expected queue.
  initial forever begin
    @(negedge clk);
    if (!rst && !midi_out) begin
      in_frame = 1;
      mst = cyc;
      mab = 0;
      for (int k = 1; k <= 9 * C + C / 2 && !mab; k++) begin
        @(negedge clk);
        if (rst) mab = 1;
        else if (k % C == C / 2) begin
          if (k / C == 0) msb = midi_out;
          else if (k / C == 9) mstop = midi_out;
          else mb[k/C-1] = midi_out;
        end
      end
      if (!mab) begin
        frames++;
        starts.push_back(mst);
        chk("start_bit", 32'(msb), 32'd0);
        chk("stop_bit", 32'(mstop), 32'd1);
        chk("frame_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("frame_byte", 32'(mb), 32'(exp_q.pop_front()));
      end
      in_frame = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  typedef struct {int k; logic out; logic bsy; logic rdy;} vec_t;
  vec_t tbl[14];
  logic [7:0] fb[7];
  int acc_k[7];
  logic rdy;
  bit bad;
  int i, k, f0;

  initial begin
    tbl[0]  = '{0,  1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1,  1'b1, 1'b1, 1'b1};
    tbl[2]  = '{2,  1'b0, 1'b1, 1'b1};
    tbl[3]  = '{5,  1'b0, 1'b1, 1'b1};
    tbl[4]  = '{6,  1'b0, 1'b1, 1'b1};
    tbl[5]  = '{21, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{22, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{25, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{26, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{34, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{38, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{40, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{41, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{45, 1'b1, 1'b0, 1'b1};
    fb = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    acc_k = '{0, 1, 2, 3, 4, 42, 82};

    #1 rst = 1'b1;
    #1;
    chk("rst_midi_out", 32'(midi_out), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single byte: line and busy against absolute offsets from the accepting edge.
    @(posedge clk);
    #1 push(8'h90);
    k = 0;
    for (int t = 0; t < 14; t++) begin
      while (k < tbl[t].k) begin
        @(posedge clk);
        #1 k++;
      end
      chk($sformatf("single_out_k%0d", k), 32'(midi_out), 32'(tbl[t].out));
      chk($sformatf("single_busy_k%0d", k), 32'(busy), 32'(tbl[t].bsy));
      chk($sformatf("single_ready_k%0d", k), 32'(tx_ready), 32'(tbl[t].rdy));
    end
    wait_drain("single_drain");

    // Back to back: start edges exactly one frame apart.
    do_reset();
    f0 = starts.size();
    push(8'h3C);
    push(8'h40);
    push(8'h7F);
    wait_drain("b2b_drain");
    chk("b2b_frames", 32'(starts.size() - f0), 32'd3);
    if (starts.size() >= f0 + 3) begin
      chk("b2b_gap01", 32'(starts[f0+1] - starts[f0]), 32'(10 * C));
      chk("b2b_gap12", 32'(starts[f0+2] - starts[f0+1]), 32'(10 * C));
    end

    // Full: tx_valid held with 7 bytes; acceptance edges relative to the first.
    do_reset();
    i = 0;
    k = 0;
    tx_valid = 1'b1;
    while (i < 7 && k < 400) begin
      tx_data = fb[i];
      rdy = tx_ready;
      if (k == 5) chk("full_ready_low", 32'(tx_ready), 32'd0);
      if (k == 41) chk("full_ready_still_low", 32'(tx_ready), 32'd0);
      if (k == 42) chk("full_ready_back", 32'(tx_ready), 32'd1);
      @(posedge clk);
      if (rdy) begin
        model(fb[i]);
        chk($sformatf("full_accept_edge%0d", i), 32'(k), 32'(acc_k[i]));
        i++;
      end
      #1 k++;
    end
    tx_valid = 1'b0;
    chk("full_all_accepted", 32'(i), 32'd7);
    wait_drain("full_drain");

    // Reset in data bit 3 of 0xA5 with two bytes queued.
    do_reset();
    push(8'hA5);
    push(8'h01);
    push(8'h02);
    repeat (17) @(posedge clk);
    #1 chk("pre_reset_bit3", 32'(midi_out), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    m_rs_v = 0;
    #1;
    chk("midrst_midi_out", 32'(midi_out), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    f0 = frames;
    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1 if (!midi_out || busy) bad = 1;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);
    chk("post_rst_no_frames", 32'(frames - f0), 32'd0);
    push(8'h55);
    wait_drain("post_rst_drain");
    chk("post_rst_new_frame", 32'(frames - f0), 32'd1);

    // Running-status sequences.
    do_reset();
    f0 = frames;
    foreach (fb[j]) fb[j] = 8'h00;
    push(8'h90); push(8'h3C); push(8'h40); push(8'h90); push(8'h3E); push(8'h40);
    wait_drain("rs1_drain");
`ifdef MIDI_TX_RUNNING_STATUS_EN
    chk("rs1_frames", 32'(frames - f0), 32'd5);
`else
    chk("rs1_frames", 32'(frames - f0), 32'd6);
`endif
    do_reset();
    f0 = frames;
    push(8'h90); push(8'h3C); push(8'hF8); push(8'h90); push(8'h3E);
    wait_drain("rs2_drain");
`ifdef MIDI_TX_RUNNING_STATUS_EN
    chk("rs2_frames", 32'(frames - f0), 32'd4);
`else
    chk("rs2_frames", 32'(frames - f0), 32'd5);
`endif
    do_reset();
    f0 = frames;
    push(8'h90); push(8'hF0); push(8'h90);
    wait_drain("rs3_drain");
    chk("rs3_frames", 32'(frames - f0), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
